wrr_arbiter: RTL and testbench
==============================

// Module: wrr_arbiter
// PURPOSE
//  Parametrised weighted round-robin arbiter with a registered one-hot grant and a valid/ready output handshake.
//  Requester k may take up to weight[k] consecutive accepted grants before priority rotates past it.
//  Sits in front of a shared resource (bus port, FIFO write side). grant_ready replaces the old stall input.
// PARAMETERS
//  N        4   number of requesters, N >= 2
//  WW       4   weight width in bits; per-requester burst limit is 1..2**WW-1
//  IDW      $clog2(N)  width of grant_id (derived, not overridden)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  req          in   N      request vector, bit k = requester k
//  weight       in   N*WW   packed weights, weight[k*WW +: WW]
//  grant        out  N      registered one-hot grant, all zero when grant_valid=0
//  grant_id     out  IDW    binary index of grant, 0 when grant_valid=0
//  grant_valid  out  1      grant is presented
//  grant_ready  in   1      consumer accepts the grant; handshake = grant_valid & grant_ready
// BEHAVIOUR
//  Reset (async, rst_n=0): grant=0, grant_id=0, grant_valid=0, ptr_q=0, owner_q=0, cnt_q=0. Takes effect immediately.
//   Mid-grant reset drops grant_valid with no handshake.
//  State: grant_q/gid_q/gvalid_q (output regs), ptr_q (IDW, RR start index), owner_q (IDW), cnt_q (WW, remaining beats of owner).
//  Slot free = !gvalid_q | grant_ready. Output regs load only when the slot is free. Otherwise grant, grant_id and grant_valid hold
//   stable, even if req drops: no withdraw.
//  Handshake on index k updates the state at the same edge:
//   k==owner_q and cnt_q!=0 -> cnt_q-1.
//   otherwise -> owner_q=k, cnt_q=eff_w(k)-1.
//   ptr_q = (k+1) mod N; wraps N-1 -> 0.
//  eff_w(k) = weight[k] if nonzero, else 1. Weight is sampled only when k becomes owner; mid-burst weight changes apply to the next burst.
//  Selection, combinational from req and post-handshake state (owner_d, cnt_d, ptr_d):
//   1. If cnt_d!=0 and req[owner_d], pick owner_d (sticky burst).
//   2. Else, round robin: first set bit of req scanning ptr_d, ptr_d+1, ... mod N.
//   3. No req -> the slot loads grant_valid=0.
//  Latency: req rising at cycle t with slot free -> grant_valid at t+1.
//   Back-to-back: the grant accepted at edge e is replaced at edge e by the next selection, giving 1 grant per cycle at full throughput.
//  Owner drops req mid-burst -> the remaining credit is forfeited when another requester is picked.
//   A later return of that requester starts a fresh burst.
//  All req=0 after a handshake: grant_valid falls next cycle; ptr_q/owner_q/cnt_q are retained.
//  Single requester continuously asserting -> granted every accepted cycle; its count reloads at exhaustion.
//  Invariants: grant is one-hot or zero; grant==(1<<grant_id) when valid.
//   A requester is starved at most sum over the other j of eff_w(j) accepted grants.
// STRUCTURE
//  Package arb_pkg: function onehot2idx, function eff_weight(w) returning 1 if w==0.
//  Sub-module rr_pick #(N): combinational; inputs req[N] and start[IDW]; outputs one-hot pick[N], pick_id, any.
//   Implemented as a doubled-vector masked priority scan.
//  Top level holds the output registers, owner/credit/pointer registers and the handshake logic, using always_ff with async reset.
// TESTING
//  1. Reset: rst_n=0 mid-grant with req=4'b1111 -> grant/grant_valid read 0 in the same cycle. After release, first grant is id 0.
//  2. Weights {1,2,3,1} (id0..3), req=4'b1111, grant_ready=1 -> id sequence 0,1,1,2,2,2,3,0,1,1...
//  3. Backpressure: grant_valid=1 on id2, grant_ready=0 for 5 cycles while req[2] drops and req[0] rises
//   -> grant stays 4'b0100 and stable. ready=1 -> accepted; next grant is id0.
//  4. Weight 0 on all, req=4'b1010 -> strict alternation 1,3,1,3. After id3, the RR wrap selects 1, not 3 again.
//  5. Mid-burst drop: weight[1]=3, req1 accepted once then deasserts, req3 high -> next grant id3.
//   req1 re-raised later -> gets a fresh 3-beat burst.
//  6. Idle: req=0 for 10 cycles -> grant_valid=0 throughout. req=4'b0001 -> grant_valid at +1 cycle, grant=4'b0001, grant_id=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared helpers for the weighted round-robin arbiter.
package arb_pkg;

    // Binary index of a one-hot vector; returns 0 for an all-zero vector.
    function automatic int unsigned onehot2idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

    // A zero weight still earns one beat so a requester can never be locked out.
    function automatic int unsigned eff_weight(input int unsigned w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] pick_id,
    output logic           any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_oh;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;

    // Rotate req so start sits at bit 0, isolate the lowest set bit, rotate the index back.
    always_comb begin
        dbl    = {req, req};
        rot    = dbl[start +: N];
        rot_oh = rot & (~rot + 1'b1);
        off    = IDW'(onehot2idx(32'(rot_oh)));
        sum    = {1'b0, start} + {1'b0, off};
        if (sum >= (IDW+1)'(N)) begin
            sum = sum - (IDW+1)'(N);
        end
        any     = |req;
        pick_id = any ? sum[IDW-1:0] : '0;
        pick    = any ? (N'(1) << pick_id) : '0;
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered one-hot grant and valid/ready handshake.
module wrr_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned N   = 4,
    parameter  int unsigned WW  = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_valid,
    input  logic            grant_ready
);

    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic           gvalid_q, gvalid_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [WW-1:0]  cnt_q, cnt_d;

    logic           hs;
    logic           slot_free;
    logic           sticky;
    logic [WW-1:0]  w_k;
    logic [N-1:0]   rr_grant;
    logic [IDW-1:0] rr_id;
    logic           rr_any;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req     (req),
        .start   (ptr_d),
        .pick    (rr_grant),
        .pick_id (rr_id),
        .any     (rr_any)
    );

    // Burst bookkeeping: an accepted grant either spends owner credit or starts a new burst.
    always_comb begin
        hs      = gvalid_q & grant_ready;
        w_k     = weight[gid_q*WW +: WW];
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (hs) begin
            if ((gid_q == owner_q) && (cnt_q != '0)) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                owner_d = gid_q;
                cnt_d   = WW'(eff_weight(32'(w_k)) - 32'd1);
            end
            ptr_d = (32'(gid_q) == N - 1) ? '0 : gid_q + 1'b1;
        end
    end

    // Next grant: keep a live burst with its owner, otherwise round robin from ptr_d.
    always_comb begin
        slot_free = !gvalid_q || grant_ready;
        sticky    = (cnt_d != '0) && req[owner_d];
        grant_d   = grant_q;
        gid_d     = gid_q;
        gvalid_d  = gvalid_q;
        if (slot_free) begin
            if (sticky) begin
                gvalid_d = 1'b1;
                gid_d    = owner_d;
                grant_d  = N'(1) << owner_d;
            end else begin
                gvalid_d = rr_any;
                gid_d    = rr_id;
                grant_d  = rr_grant;
            end
        end
    end

    // Output and arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            gid_q    <= '0;
            gvalid_q <= 1'b0;
            ptr_q    <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            grant_q  <= grant_d;
            gid_q    <= gid_d;
            gvalid_q <= gvalid_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = gid_q;
    assign grant_valid = gvalid_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_wrr_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned WW  = 4;
    localparam int unsigned IDW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_valid;
    logic            grant_ready;

    int tests;
    int fails;

    // Behavioural model: the visible grant plus burst owner, remaining beats and RR start.
    int w_arr [N];
    int m_valid;
    int m_id;
    int m_ptr;
    int m_owner;
    int m_credit;

    int exp2 [10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
    int exp4 [6]  = '{1, 3, 1, 3, 1, 3};
    int exp5 [4]  = '{1, 1, 1, 3};

    wrr_arbiter #(
        .N  (N),
        .WW (WW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .weight      (weight),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d);
        w_arr[0] = a;
        w_arr[1] = b;
        w_arr[2] = c;
        w_arr[3] = d;
        for (int i = 0; i < N; i++) begin
            weight[i*WW +: WW] = WW'(w_arr[i]);
        end
    endtask

    task automatic model_reset();
        m_valid  = 0;
        m_id     = 0;
        m_ptr    = 0;
        m_owner  = 0;
        m_credit = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int k;
        int found;
        if (m_valid != 0 && grant_ready) begin
            k = m_id;
            if (k == m_owner && m_credit > 0) begin
                m_credit = m_credit - 1;
            end else begin
                m_owner  = k;
                m_credit = ((w_arr[k] == 0) ? 1 : w_arr[k]) - 1;
            end
            m_ptr = (k + 1) % N;
        end
        if (m_valid == 0 || grant_ready) begin
            if (m_credit > 0 && req[m_owner]) begin
                m_valid = 1;
                m_id    = m_owner;
            end else begin
                found = 0;
                for (int i = 0; i < N; i++) begin
                    if (found == 0 && req[(m_ptr + i) % N]) begin
                        found = 1;
                        m_id  = (m_ptr + i) % N;
                    end
                end
                m_valid = found;
                if (found == 0) m_id = 0;
            end
        end
    endtask

    task automatic compare();
        chk("grant_valid", int'(grant_valid), m_valid);
        chk("grant_id", int'(grant_id), (m_valid != 0) ? m_id : 0);
        chk("grant", int'(grant), (m_valid != 0) ? (1 << m_id) : 0);
    endtask

    task automatic cycle();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        #1;
        compare();
        #2 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        req         = '0;
        grant_ready = 1'b0;
        set_w(1, 1, 1, 1);
        model_reset();
        #2;
        do_reset();

        // 1: asynchronous reset in the middle of a held grant
        req = 4'b1111;
        cycle();
        cycle();
        chk("t1_pre_valid", int'(grant_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_grant", int'(grant), 0);
        chk("t1_rst_valid", int'(grant_valid), 0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        grant_ready = 1'b1;
        cycle();
        chk("t1_first_id", int'(grant_id), 0);
        chk("t1_first_grant", int'(grant), 1);

        // 2: weights {1,2,3,1}, all requesting
        do_reset();
        set_w(1, 2, 3, 1);
        req         = 4'b1111;
        grant_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t2_seq", int'(grant_id), exp2[i]);
        end

        // 3: backpressure holds the grant while requests change
        do_reset();
        set_w(1, 1, 1, 1);
        req         = 4'b0100;
        grant_ready = 1'b1;
        cycle();
        chk("t3_id2", int'(grant_id), 2);
        grant_ready = 1'b0;
        req         = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_hold", int'(grant), 4);
            chk("t3_hold_valid", int'(grant_valid), 1);
        end
        grant_ready = 1'b1;
        cycle();
        chk("t3_next_grant", int'(grant), 1);
        chk("t3_next_id", int'(grant_id), 0);

        // 4: zero weights alternate between two requesters across the wrap
        do_reset();
        set_w(0, 0, 0, 0);
        req         = 4'b1010;
        grant_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t4_alt", int'(grant_id), exp4[i]);
        end

        // 5: owner drops mid-burst, later returns with a fresh burst
        do_reset();
        set_w(1, 3, 1, 1);
        req         = 4'b0010;
        grant_ready = 1'b1;
        cycle();
        chk("t5_first", int'(grant_id), 1);
        req = 4'b1000;
        cycle();
        chk("t5_switch", int'(grant_id), 3);
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t5_fresh", int'(grant_id), exp5[i]);
        end

        // 6: idle then a single request
        req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t6_idle", int'(grant_valid), 0);
        end
        req = 4'b0001;
        cycle();
        chk("t6_valid", int'(grant_valid), 1);
        chk("t6_grant", int'(grant), 1);
        chk("t6_id", int'(grant_id), 0);

        // Randomized traffic, weight changes and occasional resets against the model
        do_reset();
        set_w(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        for (int i = 0; i < 3000; i++) begin
            req         = N'($urandom);
            grant_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) req = 4'b1111;
            if ($urandom_range(0, 49) == 0) begin
                set_w(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
